// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared constants for the MIPS execute stage.
// Holds opcode and funct encodings, datapath widths and a helper that
// recognises the four multi-cycle multiply/divide instructions.
package ex_stage_pkg;

    localparam int DATA_W = 32;
    localparam int ITER   = 32;

    // Last counter value loaded when a multiply/divide starts (ITER - 1).
    localparam logic [4:0] CNT_LAST = 5'd31;

    // Primary opcodes (Ins[31:26])
    localparam logic [5:0] OP_RFORM = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-form function codes (Ins[5:0])
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // True for MULT/MULTU/DIV/DIVU; funct[1] then selects divide and
    // funct[0] selects the unsigned flavour.
    function automatic logic is_muldiv(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == OP_RFORM) &&
               ((funct == FN_MULT) || (funct == FN_MULTU) ||
                (funct == FN_DIV)  || (funct == FN_DIVU));
    endfunction

endpackage

// File: rtl/ex_stage_muldiv_unit.sv
// muldiv_unit: iterative 32-step multiply/divide engine.
// Ports:
//   CLK, RST      clock, synchronous active-low reset
//   start         a mul/div instruction is present (already gated by RST)
//   op            funct[1:0]: bit1 = divide, bit0 = unsigned
//   a, b          rs / rt operands, sampled only in the start cycle
//   stall         high in the start cycle and every BUSY cycle
//   hilo_we       one-cycle write strobe for the HI/LO registers
//   hi_wr, lo_wr  values to write when hilo_we is high
// Works on operand magnitudes; signs are re-applied on the final step.
module muldiv_unit
    import ex_stage_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              stall,
    output logic              hilo_we,
    output logic [DATA_W-1:0] hi_wr,
    output logic [DATA_W-1:0] lo_wr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    state_e            state_r;
    state_e            state_nxt_s;
    logic [4:0]        cnt_r;
    logic              is_div_r;
    logic              neg_q_r;     // negate product / quotient
    logic              neg_r_r;     // negate remainder
    logic              dz_r;        // divide by zero
    logic [DATA_W-1:0] a_raw_r;     // original dividend for the zero-divisor bypass
    logic [DATA_W-1:0] acc_hi_r;    // product high half / partial remainder
    logic [DATA_W-1:0] acc_lo_r;    // multiplier / dividend-quotient shift register
    logic [DATA_W-1:0] b_r;         // multiplicand / divisor magnitude

    logic              sgn_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [DATA_W-1:0] mag_a_s;
    logic [DATA_W-1:0] mag_b_s;
    logic [DATA_W:0]   mul_sum_s;
    logic [DATA_W:0]   div_shift_s;
    logic [DATA_W+1:0] div_diff_s;
    logic [DATA_W-1:0] step_hi_s;
    logic [DATA_W-1:0] step_lo_s;
    logic [63:0]       prod_s;

    // FSM state register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state and stall output
    always_comb begin
        state_nxt_s = state_r;
        stall       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    stall       = 1'b1;
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (cnt_r == 5'd0) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Operand sign flags and magnitudes for the capture cycle
    always_comb begin
        sgn_s   = ~op[0];
        a_neg_s = sgn_s & a[DATA_W-1];
        b_neg_s = sgn_s & b[DATA_W-1];
        if (a_neg_s) begin
            mag_a_s = 32'd0 - a;
        end else begin
            mag_a_s = a;
        end
        if (b_neg_s) begin
            mag_b_s = 32'd0 - b;
        end else begin
            mag_b_s = b;
        end
    end

    // One shift-add or restoring-divide iteration on the accumulators
    always_comb begin
        mul_sum_s   = {1'b0, acc_hi_r};
        div_shift_s = {acc_hi_r, acc_lo_r[DATA_W-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, b_r};
        step_hi_s   = acc_hi_r;
        step_lo_s   = acc_lo_r;
        if (is_div_r) begin
            // Remainder can reach 33 bits after the shift, so the trial
            // subtract is 34 bits wide and its MSB is the borrow.
            if (!div_diff_s[DATA_W+1]) begin
                step_hi_s = div_diff_s[DATA_W-1:0];
            end else begin
                step_hi_s = div_shift_s[DATA_W-1:0];
            end
            step_lo_s = {acc_lo_r[DATA_W-2:0], ~div_diff_s[DATA_W+1]};
        end else begin
            if (acc_lo_r[0]) begin
                mul_sum_s = {1'b0, acc_hi_r} + {1'b0, b_r};
            end else begin
                mul_sum_s = {1'b0, acc_hi_r};
            end
            step_hi_s = mul_sum_s[DATA_W:1];
            step_lo_s = {mul_sum_s[0], acc_lo_r[DATA_W-1:1]};
        end
    end

    // Counter and operand/accumulator registers
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_r    <= 5'd0;
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            dz_r     <= 1'b0;
            a_raw_r  <= 32'd0;
            acc_hi_r <= 32'd0;
            acc_lo_r <= 32'd0;
            b_r      <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        cnt_r    <= CNT_LAST;
                        is_div_r <= op[1];
                        neg_q_r  <= a_neg_s ^ b_neg_s;
                        neg_r_r  <= a_neg_s;
                        dz_r     <= (b == 32'd0);
                        a_raw_r  <= a;
                        acc_hi_r <= 32'd0;
                        acc_lo_r <= mag_a_s;
                        b_r      <= mag_b_s;
                    end
                end
                ST_BUSY: begin
                    acc_hi_r <= step_hi_s;
                    acc_lo_r <= step_lo_s;
                    if (cnt_r != 5'd0) begin
                        cnt_r <= cnt_r - 5'd1;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Sign fix-up, zero-divisor bypass and HI/LO write strobe on the last step
    always_comb begin
        hilo_we = (state_r == ST_BUSY) && (cnt_r == 5'd0);
        prod_s  = {step_hi_s, step_lo_s};
        hi_wr   = step_hi_s;
        lo_wr   = step_lo_s;
        if (is_div_r) begin
            if (dz_r) begin
                hi_wr = a_raw_r;
                lo_wr = 32'hFFFF_FFFF;
            end else begin
                if (neg_q_r) begin
                    lo_wr = 32'd0 - step_lo_s;
                end else begin
                    lo_wr = step_lo_s;
                end
                if (neg_r_r) begin
                    hi_wr = 32'd0 - step_hi_s;
                end else begin
                    hi_wr = step_hi_s;
                end
            end
        end else begin
            if (neg_q_r) begin
                prod_s = 64'd0 - {step_hi_s, step_lo_s};
            end else begin
                prod_s = {step_hi_s, step_lo_s};
            end
            hi_wr = prod_s[63:32];
            lo_wr = prod_s[31:0];
        end
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the single-cycle MIPS core.
// Ports:
//   CLK, RST           clock, synchronous active-low reset
//   Ins                current instruction word
//   Rdata1, Rdata2     rs / rt register operands
//   Ed32               immediate, already sign/zero extended by decode
//   Result             combinational ALU / MFHI / MFLO result
//   Stall              high while a multiply/divide has not retired
//   HI, LO             architectural HI/LO registers
// Contains the ALU, the HI/LO pair and the multiply/divide engine.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] Ins,
    input  logic [DATA_W-1:0] Rdata1,
    input  logic [DATA_W-1:0] Rdata2,
    input  logic [DATA_W-1:0] Ed32,
    output logic [DATA_W-1:0] Result,
    output logic              Stall,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO
);

    logic [5:0]        opcode_s;
    logic [5:0]        funct_s;
    logic [4:0]        shamt_s;
    logic              md_start_s;
    logic              is_mthi_s;
    logic              is_mtlo_s;
    logic              md_we_s;
    logic [DATA_W-1:0] md_hi_s;
    logic [DATA_W-1:0] md_lo_s;
    logic [DATA_W-1:0] alu_s;
    logic [DATA_W-1:0] hi_r;
    logic [DATA_W-1:0] lo_r;
    logic              unused_fields_s;

    assign opcode_s        = Ins[31:26];
    assign funct_s         = Ins[5:0];
    assign shamt_s         = Ins[10:6];
    assign unused_fields_s = ^Ins[25:16];

    // A mul/div never starts while reset is held, so Stall is low after reset.
    assign md_start_s = RST && is_muldiv(opcode_s, funct_s);
    assign is_mthi_s  = (opcode_s == OP_RFORM) && (funct_s == FN_MTHI);
    assign is_mtlo_s  = (opcode_s == OP_RFORM) && (funct_s == FN_MTLO);

    muldiv_unit u_muldiv (
        .CLK     (CLK),
        .RST     (RST),
        .start   (md_start_s),
        .op      (funct_s[1:0]),
        .a       (Rdata1),
        .b       (Rdata2),
        .stall   (Stall),
        .hilo_we (md_we_s),
        .hi_wr   (md_hi_s),
        .lo_wr   (md_lo_s)
    );

    // Combinational ALU and result mux
    always_comb begin
        alu_s = 32'd0;
        case (opcode_s)
            OP_RFORM: begin
                case (funct_s)
                    FN_ADD, FN_ADDU: alu_s = Rdata1 + Rdata2;
                    FN_SUB, FN_SUBU: alu_s = Rdata1 - Rdata2;
                    FN_AND:          alu_s = Rdata1 & Rdata2;
                    FN_OR:           alu_s = Rdata1 | Rdata2;
                    FN_XOR:          alu_s = Rdata1 ^ Rdata2;
                    FN_NOR:          alu_s = ~(Rdata1 | Rdata2);
                    FN_SLT:          alu_s = {31'd0, ($signed(Rdata1) < $signed(Rdata2))};
                    FN_SLTU:         alu_s = {31'd0, (Rdata1 < Rdata2)};
                    FN_SLL:          alu_s = Rdata2 << shamt_s;
                    FN_SRL:          alu_s = Rdata2 >> shamt_s;
                    FN_SRA:          alu_s = $signed(Rdata2) >>> shamt_s;
                    FN_SLLV:         alu_s = Rdata2 << Rdata1[4:0];
                    FN_SRLV:         alu_s = Rdata2 >> Rdata1[4:0];
                    FN_SRAV:         alu_s = $signed(Rdata2) >>> Rdata1[4:0];
                    FN_MFHI:         alu_s = hi_r;
                    FN_MFLO:         alu_s = lo_r;
                    default:         alu_s = 32'd0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: alu_s = Rdata1 + Ed32;
            OP_SLTI: alu_s = {31'd0, ($signed(Rdata1) < $signed(Ed32))};
            OP_ANDI: alu_s = Rdata1 & Ed32;
            OP_ORI:  alu_s = Rdata1 | Ed32;
            OP_XORI: alu_s = Rdata1 ^ Ed32;
            OP_LUI:  alu_s = {Ins[15:0], 16'h0000};
            default: alu_s = 32'd0;
        endcase
    end

    assign Result = alu_s;

    // HI/LO registers: engine write takes precedence over MTHI/MTLO
    always_ff @(posedge CLK) begin
        if (!RST) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (md_we_s) begin
            hi_r <= md_hi_s;
            lo_r <= md_lo_s;
        end else if (is_mthi_s) begin
            hi_r <= Rdata1;
        end else if (is_mtlo_s) begin
            lo_r <= Rdata1;
        end
    end

    assign HI = hi_r;
    assign LO = lo_r;

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed steps from the test plan followed by
// randomized ALU and multiply/divide instructions, all compared against
// an arithmetic reference model of the instruction set.
module tb_ex_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] Ins, Rdata1, Rdata2, Ed32;
    logic [31:0] Result, HI, LO;
    logic        Stall;

    int          pass_cnt  = 0;
    int          fail_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;

    logic [5:0]  rfn [21] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                              6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                              6'h10, 6'h12, 6'h08, 6'h11, 6'h13};
    logic [5:0]  iop [11] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                              6'h23, 6'h2B, 6'h04, 6'h03};

    ex_stage dut (
        .CLK    (CLK),
        .RST    (RST),
        .Ins    (Ins),
        .Rdata1 (Rdata1),
        .Rdata2 (Rdata2),
        .Ed32   (Ed32),
        .Result (Result),
        .Stall  (Stall),
        .HI     (HI),
        .LO     (LO)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] rt(input logic [5:0] fn, input logic [4:0] sh);
        return {6'd0, 5'd9, 5'd10, 5'd11, sh, fn};
    endfunction

    function automatic logic [31:0] it(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd9, 5'd10, imm};
    endfunction

    // Instruction-set view of the single-cycle result.
    function automatic logic [31:0] ref_alu(input logic [31:0] ins, a, b, imm, hi, lo);
        longint sa, sb, si, t;
        int     sh;
        int     vsh;
        sa  = $signed(a);
        sb  = $signed(b);
        si  = $signed(imm);
        sh  = int'(ins[10:6]);
        vsh = int'(a[4:0]);
        if (ins[31:26] == 6'h00) begin
            case (ins[5:0])
                6'h20, 6'h21: return a + b;
                6'h22, 6'h23: return a - b;
                6'h24: return a & b;
                6'h25: return a | b;
                6'h26: return a ^ b;
                6'h27: return ~(a | b);
                6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
                6'h2B: return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
                6'h00: return b << sh;
                6'h02: return b >> sh;
                6'h03: begin t = sb >>> sh; return t[31:0]; end
                6'h04: return b << vsh;
                6'h06: return b >> vsh;
                6'h07: begin t = sb >>> vsh; return t[31:0]; end
                6'h10: return hi;
                6'h12: return lo;
                default: return 32'd0;
            endcase
        end
        case (ins[31:26])
            6'h08, 6'h09, 6'h23, 6'h2B: return a + imm;
            6'h0A: return (sa < si) ? 32'd1 : 32'd0;
            6'h0C: return a & imm;
            6'h0D: return a | imm;
            6'h0E: return a ^ imm;
            6'h0F: return {ins[15:0], 16'h0000};
            default: return 32'd0;
        endcase
    endfunction

    // Expected {HI, LO} of a multiply/divide, via 64-bit arithmetic.
    function automatic logic [63:0] ref_md(input logic [5:0] fn, input logic [31:0] a, b);
        longint      sa, sb, q, r, p;
        logic [63:0] up;
        sa = $signed(a);
        sb = $signed(b);
        case (fn)
            6'h18: begin p = sa * sb; return p; end
            6'h19: begin up = {32'd0, a} * {32'd0, b}; return up; end
            6'h1A: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            6'h1B: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic alu_step(input logic [31:0] ins, a, b, imm, input string tag);
        next_cycle();
        Ins = ins; Rdata1 = a; Rdata2 = b; Ed32 = imm;
        #1;
        chk({tag, " result"}, Result, ref_alu(ins, a, b, imm, mhi, mlo));
        chk({tag, " stall"}, {31'd0, Stall}, 32'd0);
        chk({tag, " hi"}, HI, mhi);
        chk({tag, " lo"}, LO, mlo);
        if (ins[31:26] == 6'h00 && ins[5:0] == 6'h11) mhi = a;
        if (ins[31:26] == 6'h00 && ins[5:0] == 6'h13) mlo = a;
    endtask

    task automatic md_step(input logic [5:0] fn, input logic [31:0] a, b,
                           input string tag, input bit scramble);
        logic [63:0] e;
        int          n;
        next_cycle();
        Ins = rt(fn, 5'd0); Rdata1 = a; Rdata2 = b; Ed32 = $urandom;
        #1;
        n = 0;
        while (Stall === 1'b1 && n < 40) begin
            n++;
            if (scramble && n == 5) begin
                Rdata1 = $urandom;
                Rdata2 = $urandom;
            end
            next_cycle();
            #1;
        end
        e = ref_md(fn, a, b);
        chk({tag, " stall cycles"}, 32'(n), 32'd33);
        chk({tag, " hi"}, HI, e[63:32]);
        chk({tag, " lo"}, LO, e[31:0]);
        chk({tag, " result"}, Result, 32'd0);
        mhi = e[63:32];
        mlo = e[31:0];
    endtask

    initial begin
        logic [31:0] ins;
        logic [5:0]  fn;
        logic [31:0] a, b;

        RST = 1'b0; Ins = 32'd0; Rdata1 = 32'd0; Rdata2 = 32'd0; Ed32 = 32'd0;
        next_cycle();
        next_cycle();
        chk("reset hi", HI, 32'd0);
        chk("reset lo", LO, 32'd0);
        chk("reset stall", {31'd0, Stall}, 32'd0);
        RST = 1'b1;

        // Directed single-cycle cases
        alu_step(rt(6'h21, 5'd0), 32'hFFFF_FFFF, 32'd1, 32'd0, "addu wrap");
        alu_step(rt(6'h2A, 5'd0), 32'hFFFF_FFFF, 32'd1, 32'd0, "slt");
        alu_step(rt(6'h2B, 5'd0), 32'hFFFF_FFFF, 32'd1, 32'd0, "sltu");
        alu_step(rt(6'h03, 5'd4), 32'd0, 32'h8000_0000, 32'd0, "sra");
        alu_step(it(6'h0F, 16'h1234), 32'd7, 32'd0, 32'h0000_1234, "lui");
        chk("addu wrap exact", ref_alu(rt(6'h21, 5'd0), 32'hFFFF_FFFF, 32'd1, 32'd0, mhi, mlo), 32'd0);

        // Multiply / divide from the plan
        md_step(6'h18, 32'hFFFF_FFFD, 32'd7, "mult -3x7", 1'b0);
        chk("mult hi const", HI, 32'hFFFF_FFFF);
        chk("mult lo const", LO, 32'hFFFF_FFEB);
        alu_step(rt(6'h12, 5'd0), 32'd0, 32'd0, 32'd0, "mflo after mult");
        md_step(6'h1A, 32'hFFFF_FFF9, 32'd2, "div -7/2", 1'b0);
        chk("div lo const", LO, 32'hFFFF_FFFD);
        md_step(6'h1B, 32'd7, 32'd2, "divu 7/2", 1'b0);
        md_step(6'h1B, 32'd5, 32'd0, "divu 5/0", 1'b0);
        chk("divu0 hi const", HI, 32'd5);
        md_step(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1", 1'b0);
        chk("div min lo const", LO, 32'h8000_0000);

        // Reset in BUSY cycle 10 discards the partial result
        next_cycle();
        Ins = rt(6'h19, 5'd0); Rdata1 = 32'hFFFF_FFFF; Rdata2 = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) next_cycle();
        chk("busy stall", {31'd0, Stall}, 32'd1);
        RST = 1'b0;
        Ins = 32'd0;
        next_cycle();
        RST = 1'b1;
        #1;
        chk("midrst stall", {31'd0, Stall}, 32'd0);
        chk("midrst hi", HI, 32'd0);
        chk("midrst lo", LO, 32'd0);
        mhi = 32'd0;
        mlo = 32'd0;
        md_step(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu rerun", 1'b0);
        chk("multu hi const", HI, 32'hFFFF_FFFE);

        // MTHI / MFHI and back-to-back engine use
        alu_step(rt(6'h11, 5'd0), 32'hA5A5_A5A5, 32'd0, 32'd0, "mthi");
        alu_step(rt(6'h10, 5'd0), 32'd0, 32'd0, 32'd0, "mfhi");
        chk("mfhi const", HI, 32'hA5A5_A5A5);
        md_step(6'h19, 32'd2, 32'd3, "b2b multu", 1'b0);
        md_step(6'h1B, 32'd9, 32'd4, "b2b divu", 1'b0);

        // Random single-cycle instructions
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                ins = rt(rfn[$urandom_range(0, 20)], 5'($urandom));
            end else begin
                ins = it(iop[$urandom_range(0, 10)], 16'($urandom));
            end
            alu_step(ins, $urandom, $urandom, $urandom, "rand alu");
        end

        // Random multiply/divide with operands changing mid-operation
        for (int k = 0; k < 8; k++) begin
            fn = 6'h18 + 6'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
            if (k[0]) a = a >> $urandom_range(0, 31);
            md_step(fn, a, b, "rand md", 1'b1);
            alu_step(rt(6'h10, 5'd0), 32'd0, 32'd0, 32'd0, "rand mfhi");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
